// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Purpose : shared definitions for the instruction-fetch slice. Holds the
//           tinyriscv bus widths, reset address, NOP encoding, pipeline hold
//           codes, the jump-enable level and the FIFO entry type.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;
    localparam logic [InstBus-1:0]     INST_NOP     = 32'h0000_0013;
    localparam logic                   JumpEnable   = 1'b1;

    // Pipeline control codes issued by ctrl. Any unlisted code behaves like a pause.
    typedef enum logic [1:0] {
        Pipe_Flow  = 2'd0,
        Pipe_Pause = 2'd1,
        Pipe_Clear = 2'd2
    } hold_flag_e;

    // One buffered fetch response: the address it was fetched from plus the word.
    typedef struct packed {
        logic [InstAddrBus-1:0] addr;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Purpose : rib instruction-port bundle between the fetch unit and memory.
// Signals : req    fetch request valid        (master -> slave)
//           addr   fetch address              (master -> slave)
//           gnt    request accepted this cycle (slave -> master)
//           rvalid response valid, in order    (slave -> master)
//           rdata  response instruction        (slave -> master)
// ---------------------------------------------------------------------------
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   req;
    logic [InstAddrBus-1:0] addr;
    logic                   gnt;
    logic                   rvalid;
    logic [InstBus-1:0]     rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch_fifo.sv
// ---------------------------------------------------------------------------
// if_fetch_fifo
// Purpose : synchronous FIFO of fetch_entry_t used as the fetch response
//           buffer. DEPTH must be a power of two so the pointers wrap freely.
// Ports   : clk_i/rst_ni   clock, async active-low reset
//           push_i/data_i  write an entry
//           pop_i/data_o   consume the head entry (data_o is the head)
//           flush_i        discard all entries, wins over push/pop
//           count_o/full_o/empty_o  occupancy status
// ---------------------------------------------------------------------------
module if_fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               data_i,
    output fetch_entry_t               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wrPtr_q;
    logic [PtrW-1:0] rdPtr_q;
    logic [CntW-1:0] count_q;

    // Pointer and occupancy bookkeeping. A flush simply rewinds everything,
    // which is what makes a pipeline clear cheap. Push and pop together leave
    // the count unchanged, including the full case.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PtrOne;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + PtrOne;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CntOne;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CntOne;
            end
        end
    end

    // Storage array carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Purpose : instruction-fetch front end. Owns the PC, issues credit-limited
//           requests on the rib instruction port, buffers in-order responses
//           in a small FIFO and drives the IF/ID instruction register under
//           the Pipe_Flow / Pipe_Pause / Pipe_Clear control from ctrl.
// Ports   : clk_i, rst_ni        clock, async active-low reset
//           hold_flag_i          pipeline hold code from ctrl
//           jump_flag_i/addr_i   PC redirect, honoured only with Pipe_Clear
//           ibus (master)        request/grant/response instruction port
//           inst_o, inst_addr_o  IF/ID instruction and its address
//           inst_valid_o         IF/ID entry is a real instruction
// Config  : IF_BYPASS_EN - when defined, a kept response arriving under
//           Pipe_Flow with the FIFO empty is written straight into IF/ID.
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [InstAddrBus-1:0] RESET_ADDR = CpuResetAddr
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  hold_flag_e             hold_flag_i,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    if_fetch_if.master             ibus,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic                   inst_valid_o
);

    localparam int CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0]        CntOne   = CntW'(1);
    localparam logic [CntW:0]          CreditLim = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [InstAddrBus-1:0] PcStep   = InstAddrBus'(4);

    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] respAddr_q, respAddr_d;
    logic [CntW-1:0]        outstanding_q, outstanding_d;
    logic [CntW-1:0]        drop_q, drop_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic [InstAddrBus-1:0] instAddr_q, instAddr_d;
    logic                   instValid_q, instValid_d;

    logic [CntW-1:0] fifoCount;
    logic            fifoFull, fifoEmpty;
    logic            fifoPush, fifoPop, fifoFlush;
    fetch_entry_t    fifoIn, fifoHead;

    logic            isFlow, isClear;
    logic [CntW:0]   inFlight;
    logic            fire, respKeep, bypass;

    // Credits cover both buffered and in-flight entries, so the FIFO can never
    // overflow. The request only drops on a clear; otherwise it can only rise
    // while waiting for gnt, keeping req/addr stable until accepted.
    assign isFlow   = (hold_flag_i == Pipe_Flow);
    assign isClear  = (hold_flag_i == Pipe_Clear);
    assign inFlight = {1'b0, fifoCount} + {1'b0, outstanding_q};
    assign ibus.req  = (inFlight < CreditLim) && !isClear;
    assign ibus.addr = pc_q;
    assign fire      = ibus.req && ibus.gnt;
    assign respKeep  = ibus.rvalid && (drop_q == '0);

`ifdef IF_BYPASS_EN
    assign bypass = isFlow && fifoEmpty && respKeep;
`else
    assign bypass = 1'b0;
`endif

    assign fifoIn    = '{addr: respAddr_q, inst: ibus.rdata};
    assign fifoPush  = respKeep && !bypass && !isClear && (!fifoFull || fifoPop);
    assign fifoPop   = isFlow && !fifoEmpty;
    assign fifoFlush = isClear;

    if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .flush_i (fifoFlush),
        .data_i  (fifoIn),
        .data_o  (fifoHead),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Next-state logic for the PC, response tracking and the IF/ID register.
    // The clear branch comes last so it overrides any push/pop decisions made
    // above; a jump without a clear is deliberately ignored.
    always_comb begin
        pc_d          = pc_q;
        respAddr_d    = respAddr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        inst_d        = inst_q;
        instAddr_d    = instAddr_q;
        instValid_d   = instValid_q;

        if (fire) begin
            pc_d = pc_q + PcStep;
        end

        case ({fire, ibus.rvalid})
            2'b10:   outstanding_d = outstanding_q + CntOne;
            2'b01:   outstanding_d = outstanding_q - CntOne;
            default: outstanding_d = outstanding_q;
        endcase

        if (ibus.rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CntOne;
        end

        if (respKeep) begin
            respAddr_d = respAddr_q + PcStep;
        end

        if (isFlow) begin
            if (bypass) begin
                inst_d      = ibus.rdata;
                instAddr_d  = respAddr_q;
                instValid_d = 1'b1;
            end else if (!fifoEmpty) begin
                inst_d      = fifoHead.inst;
                instAddr_d  = fifoHead.addr;
                instValid_d = 1'b1;
            end else begin
                inst_d      = INST_NOP;
                instValid_d = 1'b0;
            end
        end

        if (isClear) begin
            inst_d      = INST_NOP;
            instValid_d = 1'b0;
            drop_d      = outstanding_d;
            if (jump_flag_i == JumpEnable) begin
                pc_d       = jump_addr_i;
                respAddr_d = jump_addr_i;
            end else begin
                pc_d       = pc_q;
                respAddr_d = pc_q;
            end
        end
    end

    // State registers; reset leaves an empty pipeline pointing at RESET_ADDR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_ADDR;
            respAddr_q    <= RESET_ADDR;
            outstanding_q <= '0;
            drop_q        <= '0;
            inst_q        <= INST_NOP;
            instAddr_q    <= '0;
            instValid_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            respAddr_q    <= respAddr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            inst_q        <= inst_d;
            instAddr_q    <= instAddr_d;
            instValid_q   <= instValid_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = instAddr_q;
    assign inst_valid_o = instValid_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A small bus responder grants while gntEn is
// set and returns each granted address one cycle later (while respEn is set)
// with an instruction word derived from that address.
// ---------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

`ifdef IF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    hold_flag_e  holdFlag;
    logic        jumpFlag;
    logic [31:0] jumpAddr;
    logic [31:0] instOut;
    logic [31:0] instAddrOut;
    logic        instValidOut;

    bit          gntEn;
    bit          respEn;
    logic [31:0] pendQ [$];

    int assertCount = 0;
    int failCount   = 0;

    if_fetch_if ibus ();

    if_fetch #(
        .FIFO_DEPTH (2),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .hold_flag_i  (holdFlag),
        .jump_flag_i  (jumpFlag),
        .jump_addr_i  (jumpAddr),
        .ibus         (ibus),
        .inst_o       (instOut),
        .inst_addr_o  (instAddrOut),
        .inst_valid_o (instValidOut)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory returns for a given fetch address.
    function automatic logic [31:0] instFor(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Bus responder: acts 1 unit after each falling edge so that the stimulus
    // written on that falling edge has already settled.
    initial begin
        ibus.gnt    = 1'b0;
        ibus.rvalid = 1'b0;
        ibus.rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            ibus.rvalid = 1'b0;
            ibus.rdata  = '0;
            if (respEn && pendQ.size() > 0) begin
                ibus.rvalid = 1'b1;
                ibus.rdata  = instFor(pendQ.pop_front());
            end
            ibus.gnt = gntEn;
            if (ibus.req && ibus.gnt) begin
                pendQ.push_back(ibus.addr);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input hold_flag_e h, input logic j, input logic [31:0] ja,
                                 input bit g, input bit r);
        @(negedge clk);
        holdFlag = h;
        jumpFlag = j;
        jumpAddr = ja;
        gntEn    = g;
        respEn   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sampleEdge();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the next valid IF/ID entry and checks it.
    task automatic expectNextInst(input string tag, input logic [31:0] expAddr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            sampleEdge();
            if (instValidOut === 1'b1) found = 1'b1;
        end
        checkOutput({tag, "_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            checkOutput({tag, "_addr"}, instAddrOut, expAddr);
            checkOutput({tag, "_inst"}, instOut, instFor(expAddr));
        end
    endtask

    // Stop fetching, let every outstanding response return and the FIFO drain.
    task automatic drain();
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        holdFlag = Pipe_Flow;
        jumpFlag = 1'b0;
        jumpAddr = '0;
        gntEn    = 1'b0;
        respEn   = 1'b0;

        // ---- 1: reset values, then a streaming fetch from address 0 ----
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_inst",      instOut,           INST_NOP);
        checkOutput("rst_inst_addr", instAddrOut,       32'h0);
        checkOutput("rst_valid",     {31'd0, instValidOut}, 32'd0);
        checkOutput("rst_ibus_addr", ibus.addr,         32'h0);
        checkOutput("rst_ibus_req",  {31'd0, ibus.req}, 32'd1);
        @(negedge clk);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
        rst_n = 1'b1;
        expectNextInst("t1_i0", 32'h0000_0000);
        expectNextInst("t1_i1", 32'h0000_0004);
        expectNextInst("t1_i2", 32'h0000_0008);
        expectNextInst("t1_i3", 32'h0000_000C);

        // ---- 2: pause with the bus still answering ----
        applyStimulus(Pipe_Pause, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            sampleEdge();
            checkOutput("t2_hold_addr",  instAddrOut, 32'h0000_000C);
            checkOutput("t2_hold_valid", {31'd0, instValidOut}, 32'd1);
        end
        checkOutput("t2_hold_inst",  instOut, instFor(32'h0000_000C));
        checkOutput("t2_req_off",    {31'd0, ibus.req}, 32'd0);
        checkOutput("t2_pc",         ibus.addr, 32'h0000_0018);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
        expectNextInst("t2_i0", 32'h0000_0010);
        expectNextInst("t2_i1", 32'h0000_0014);
        expectNextInst("t2_i2", 32'h0000_0018);

        // ---- 3: two outstanding requests, then clear + jump to 0x100 ----
        drain();
        applyStimulus(Pipe_Clear, JumpEnable, 32'h0000_0080, 1'b0, 1'b1);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) sampleEdge();
        checkOutput("t3_req_off", {31'd0, ibus.req}, 32'd0);
        checkOutput("t3_pc",      ibus.addr, 32'h0000_0088);
        applyStimulus(Pipe_Clear, JumpEnable, 32'h0000_0100, 1'b1, 1'b0);
        sampleEdge();
        checkOutput("t3_clr_valid", {31'd0, instValidOut}, 32'd0);
        checkOutput("t3_clr_inst",  instOut, INST_NOP);
        checkOutput("t3_jump_pc",   ibus.addr, 32'h0000_0100);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
        expectNextInst("t3_i0", 32'h0000_0100);

        // ---- 4: clear while gnt and rvalid are both high ----
        drain();
        applyStimulus(Pipe_Clear, JumpEnable, 32'h0000_0200, 1'b0, 1'b1);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        applyStimulus(Pipe_Clear, 1'b0, 32'h0, 1'b1, 1'b1);
        #2;
        checkOutput("t4_clr_req", {31'd0, ibus.req}, 32'd0);
        sampleEdge();
        checkOutput("t4_clr_valid", {31'd0, instValidOut}, 32'd0);
        checkOutput("t4_clr_inst",  instOut, INST_NOP);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
        sampleEdge();
        checkOutput("t4_no_stale", {31'd0, instValidOut}, 32'd0);
        expectNextInst("t4_i0", 32'h0000_0208);

        // ---- 5: PC wrap at the top of the address space ----
        drain();
        applyStimulus(Pipe_Clear, JumpEnable, 32'hFFFF_FFFC, 1'b0, 1'b1);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("t5_pc_top", ibus.addr, 32'hFFFF_FFFC);
        sampleEdge();
        checkOutput("t5_pc_wrap", ibus.addr, 32'h0000_0000);
        expectNextInst("t5_i0", 32'hFFFF_FFFC);
        expectNextInst("t5_i1", 32'h0000_0000);

        // ---- 6: rvalid -> inst_valid_o latency on an empty FIFO ----
        drain();
        applyStimulus(Pipe_Clear, JumpEnable, 32'h0000_0300, 1'b0, 1'b1);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(Pipe_Flow, 1'b0, 32'h0, 1'b0, 1'b1);
        sampleEdge();
        checkOutput("t6_edge1_valid", {31'd0, instValidOut}, Bypass ? 32'd1 : 32'd0);
        sampleEdge();
        checkOutput("t6_edge2_valid", {31'd0, instValidOut}, Bypass ? 32'd0 : 32'd1);
        checkOutput("t6_edge2_addr",  instAddrOut, 32'h0000_0300);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
